// File: rtl/pipeline_dbg_seq_if.sv
// Host/pipeline-facing signal bundle for pipeline_dbg_seq.
// slave is the sequencer side; master is the host link plus pipeline side.
interface pipeline_dbg_seq_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CYC_W  = 16
);
    logic              start;
    logic [CYC_W-1:0]  run_cycles;

    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;

    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    logic              core_rst;
    logic              core_stall;
    logic [DATA_W-1:0] pc_in;

    logic [REG_AW-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;

    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;

    logic              busy;
    logic              done;
    logic              ovf;

    modport master (
        output start, run_cycles, ld_valid, ld_data, ld_last, pc_in, rf_rdata, dump_ready,
        input  ld_ready, imem_we, imem_addr, imem_wdata, core_rst, core_stall, rf_raddr,
               dump_valid, dump_data, dump_last, busy, done, ovf
    );

    modport slave (
        input  start, run_cycles, ld_valid, ld_data, ld_last, pc_in, rf_rdata, dump_ready,
        output ld_ready, imem_we, imem_addr, imem_wdata, core_rst, core_stall, rf_raddr,
               dump_valid, dump_data, dump_last, busy, done, ovf
    );
endinterface

// File: rtl/pipeline_dbg_seq.sv
// Bring-up sequencer: loads imem with the core held in reset, runs it, then dumps the regfile.
// Define PC_DUMP_EN to prepend the PC captured at halt to the dump stream.
module pipeline_dbg_seq #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned CYC_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    pipeline_dbg_seq_if.slave   bus
);

`ifdef PC_DUMP_EN
    localparam int unsigned NumWords = NUM_REGS + 1;
`else
    localparam int unsigned NumWords = NUM_REGS;
`endif
    // One extra bit so the index can reach NumWords (a register count of 2^REG_AW plus the PC).
    localparam int unsigned IdxW = REG_AW + 1;

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StHalt, StDump, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CYC_W-1:0]  cyc_q;
    logic [IdxW-1:0]   idx_q;
    logic              ovf_q;
    logic              ld_ready_q;
    logic              core_rst_q;
    logic              core_stall_q;
    logic              busy_q;
    logic              done_q;
    logic              dump_valid_q;
    logic [DATA_W-1:0] dump_data_q;
    logic              dump_last_q;

    logic              ld_fire;
    logic              addr_full;
    logic              dump_fire;
    logic              dump_load;
    logic [CYC_W-1:0]  run_len;
    logic [IdxW-1:0]   rf_idx;
    logic [DATA_W-1:0] dump_word;

    assign ld_fire   = bus.ld_valid & ld_ready_q;
    assign addr_full = (addr_q == {ADDR_W{1'b1}});
    assign dump_fire = dump_valid_q & bus.dump_ready;
    assign dump_load = (state_q == StDump) && (!dump_valid_q || bus.dump_ready) &&
                       (idx_q < IdxW'(NumWords));
    // RUN counts down to zero inclusive, so a zero request still yields one cycle.
    assign run_len   = (bus.run_cycles == '0) ? '0 : bus.run_cycles - 1'b1;

`ifdef PC_DUMP_EN
    logic [DATA_W-1:0] pc_q;

    assign rf_idx    = (idx_q == '0) ? '0 : idx_q - 1'b1;
    assign dump_word = (idx_q == '0) ? pc_q : bus.rf_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
        end else if (state_q == StHalt) begin
            pc_q <= bus.pc_in;
        end
    end
`else
    logic unused_pc;

    assign unused_pc = ^bus.pc_in;
    assign rf_idx    = idx_q;
    assign dump_word = bus.rf_rdata;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (bus.start) state_d = StLoad;
            StLoad:         if (ld_fire && (bus.ld_last || addr_full)) state_d = StRun;
            StRun:          if (cyc_q == '0) state_d = StHalt;
            StHalt:         state_d = StDump;
            StDump:         if (dump_fire && dump_last_q) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            cyc_q        <= '0;
            idx_q        <= '0;
            ovf_q        <= 1'b0;
            ld_ready_q   <= 1'b0;
            core_rst_q   <= 1'b0;
            core_stall_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= '0;
            dump_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_ready_q   <= (state_d == StLoad);
            core_rst_q   <= !(state_d inside {StIdle, StLoad});
            core_stall_q <= state_d inside {StHalt, StDump, StDone};
            busy_q       <= state_d inside {StLoad, StRun, StHalt, StDump};
            done_q       <= (state_d == StDone);

            case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        addr_q <= '0;
                        idx_q  <= '0;
                        ovf_q  <= 1'b0;
                        cyc_q  <= run_len;
                    end
                end
                StLoad: begin
                    // The top address is written once and never wrapped past.
                    if (ld_fire) begin
                        if (!addr_full) begin
                            addr_q <= addr_q + 1'b1;
                        end else if (!bus.ld_last) begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (cyc_q != '0) begin
                        cyc_q <= cyc_q - 1'b1;
                    end
                end
                StDump: begin
                    if (dump_load) begin
                        dump_valid_q <= 1'b1;
                        dump_data_q  <= dump_word;
                        dump_last_q  <= (idx_q == IdxW'(NumWords - 1));
                        idx_q        <= idx_q + 1'b1;
                    end else if (dump_fire) begin
                        dump_valid_q <= 1'b0;
                        dump_last_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ld_ready   = ld_ready_q;
    assign bus.imem_we    = ld_fire;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = ld_fire ? bus.ld_data : '0;
    assign bus.core_rst   = core_rst_q;
    assign bus.core_stall = core_stall_q;
    assign bus.rf_raddr   = (state_q == StDump) ? REG_AW'(rf_idx) : '0;
    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_data  = dump_data_q;
    assign bus.dump_last  = dump_last_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: doc/pipeline_dbg_seq.md
# pipeline_dbg_seq

Parametrised bring-up and debug sequencer for `pipeline_top`. It streams a program image into instruction memory while holding the core in reset, then releases the core for a programmable number of cycles. After that it freezes the core and streams a register-file snapshot (optionally preceded by the PC) out on a valid/ready port. It replaces bench-only memory preloading and register printing with a synthesizable block that sits between a host link and the pipeline.

## Interface
Parameters:
- `DATA_W`, 32: instruction, register and dump word width.
- `ADDR_W`, 10: instruction memory word address width; depth is 2^ADDR_W.
- `REG_AW`, 5: register-file read address width.
- `NUM_REGS`, 32: registers dumped (indices 0..NUM_REGS-1); must satisfy 1..2^REG_AW.
- `CYC_W`, 16: run-cycle counter width.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load/run/dump sequence.
- `run_cycles`  in  CYC_W  core run length; sampled when `start` is accepted.
- `ld_valid` / `ld_ready`  in / out  1  load stream handshake.
- `ld_data`  in  DATA_W  instruction word.
- `ld_last`  in  1  marks the final image word.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_addr`  out  ADDR_W  instruction memory write address.
- `imem_wdata`  out  DATA_W  instruction memory write data.
- `core_rst`  out  1  active-low reset to the pipeline.
- `core_stall`  out  1  freezes the pipeline (PC and all stage registers).
- `pc_in`  in  DATA_W  current PC from the pipeline.
- `rf_raddr`  out  REG_AW  register-file debug read address.
- `rf_rdata`  in  DATA_W  combinational read data for `rf_raddr`.
- `dump_valid` / `dump_ready`  out / in  1  dump stream handshake.
- `dump_data`  out  DATA_W  dump word.
- `dump_last`  out  1  marks the final dump word.
- `busy`  out  1  sequence in progress.
- `done`  out  1  dump complete.
- `ovf`  out  1  sticky flag: image filled memory without `ld_last`.

## Operation
- States: IDLE, LOAD, RUN, HALT, DUMP, DONE.
- IDLE:
  - `core_rst`=0.
  - `start` moves to LOAD and clears the word counter, `ovf` and `done`.
  - `start` is ignored in every state except IDLE and DONE.
- LOAD:
  - `ld_ready`=1 and `core_rst`=0.
  - Each accepted word (`ld_valid & ld_ready`) combinationally drives `imem_we`=1, `imem_addr`=counter and `imem_wdata`=`ld_data`; the counter then increments.
  - Accepting a word with `ld_last` moves to RUN.
  - Accepting the word at address 2^ADDR_W-1 without `ld_last` sets `ovf` and moves to RUN; no wrap-around, and address 0 is never overwritten.
- RUN:
  - `core_rst`=1 and `core_stall`=0.
  - Lasts exactly max(`run_cycles`,1) cycles, then moves to HALT.
- HALT:
  - Lasts one cycle with `core_stall`=1 and `core_rst`=1.
  - Captures `pc_in` into the PC snapshot register.
- DUMP:
  - `core_stall`=1 and `core_rst`=1, so register contents are preserved.
  - `rf_raddr` walks indices 0..NUM_REGS-1.
  - The output register loads whenever `!dump_valid || dump_ready`.
  - `dump_data` and `dump_last` hold stable while `dump_valid & !dump_ready`.
  - `dump_last`=1 only on the final word. Accepting it moves to DONE.
- DONE:
  - `done`=1, `core_stall`=1, `core_rst`=1.
  - `start` re-enters LOAD, which drops `core_rst` to 0.
- `busy`=1 in LOAD, RUN, HALT and DUMP.
- Reset mid-operation: all state is abandoned. Every output takes its reset value and the state returns to IDLE.
- Reset values: `ld_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `core_rst` 0, `core_stall` 0, `rf_raddr` 0, `dump_valid` 0, `dump_data` 0, `dump_last` 0, `busy` 0, `done` 0, `ovf` 0.

## Timing
- `start` sampled at edge k: LOAD from k+1, so `ld_ready` is high in cycle k+1.
- Load throughput: one word per cycle; the write occurs in the same cycle as the handshake.
- `ld_last` accepted at edge m: `core_rst`=1 from cycle m+1.
- RUN of N cycles: HALT occupies cycle m+1+N, and DUMP is entered at the following edge.
- First `dump_valid` appears one cycle after DUMP entry.
- With `dump_ready` held high, one word is transferred per cycle with no bubbles.
- `done` rises the cycle after the `dump_last` handshake.

## Configuration
- `PC_DUMP_EN` defined: the dump stream is NUM_REGS+1 words, with the PC snapshot first, followed by registers 0..NUM_REGS-1.
- `PC_DUMP_EN` not defined: the dump stream is NUM_REGS words. `pc_in` is unused, and the snapshot register and its HALT capture are not built.

## Test plan
- Three-word image, `run_cycles`=5, `dump_ready`=1 → writes to addresses 0..2; `core_rst` high for exactly 5 cycles before HALT; NUM_REGS consecutive dump words with `dump_last` on the final word; `done`=1.
- `ld_valid` toggling every other cycle → `imem_addr` increments only on accepted words; no gaps or duplicate addresses.
- `ADDR_W`=2, six words with no `ld_last` → four writes (0..3), `ovf`=1, then RUN; remaining words are not accepted.
- `dump_ready` low for 3 cycles mid-dump → `dump_data` and `dump_last` stable; no word skipped; register 4 reads back its known value.
- Register values R0=0, R1=0x11, R2=0x22 with `PC_DUMP_EN` defined and pipeline PC=0x14 → stream is 0x14, 0, 0x11, 0x22, ….
- `rst` asserted during DUMP, then a new `start` with `run_cycles`=0 → all outputs at reset values, then a full sequence with a 1-cycle RUN.
